// File: rtl/pipe_scheduler_pkg.sv
// Shared definitions for pipe_scheduler, mirrored by the host software register/pipe map.
// Holds the header tag, the scheduler state encoding and the drop-counter width.
package pipe_scheduler_pkg;

  localparam logic [3:0] HEADER_TAG = 4'hA;
  localparam int         DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel after last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand_idx;

  // Scan last_grant+1 .. last_grant+N; the first hit wins and later hits are masked.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    cand_idx     = '0;
    for (int i = 1; i <= N; i++) begin
      cand_idx = IDX_W'((int'(last_grant) + i) % N);
      if (grant_onehot == '0 && request[cand_idx]) begin
        grant_onehot[cand_idx] = 1'b1;
        grant_idx              = cand_idx;
      end
    end
  end

  assign grant_valid = |request;

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: holds one sample per channel and serialises them round-robin into the pipe FIFO.
// Define PIPE_SCHED_HEADER_EN for two-word frames {tag, chan, seq} + data; default emits data words only.
module pipe_scheduler
  import pipe_scheduler_pkg::*;
#(
  parameter int N_ADC      = 8,
  parameter int W_ADC_DATA = 18,
  parameter int W_EP       = 16
) (
  input  logic                        clk50_in,
  input  logic                        rst_n_in,
  input  logic [N_ADC-1:0]            osf_data_valid_in,
  input  logic [N_ADC*W_ADC_DATA-1:0] osf_data_packed_in,
  input  logic [N_ADC-1:0]            chan_enable_in,
  input  logic                        fifo_full_in,
  output logic                        fifo_wr_en_out,
  output logic [W_EP-1:0]             fifo_data_out,
  output logic [N_ADC*DROP_CNT_W-1:0] drop_count_out,
  output logic                        busy_out
);

  localparam int               IDX_W    = (N_ADC > 1) ? $clog2(N_ADC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ADC - 1);

`ifdef PIPE_SCHED_HEADER_EN
  localparam sched_state_t GRANT_STATE = ST_HEADER;
`else
  localparam sched_state_t GRANT_STATE = ST_DATA;
`endif

  sched_state_t                         state, state_next;
  logic [N_ADC-1:0]                     pending;
  logic [N_ADC-1:0][W_ADC_DATA-1:0]     held;
  logic [N_ADC-1:0][DROP_CNT_W-1:0]     drop_cnt;
  logic [IDX_W-1:0]                     cur_chan, last_grant, grant_idx;
  logic [N_ADC-1:0]                     request, grant_onehot;
  logic                                 grant_valid;
  logic [W_ADC_DATA-1:0]                sel_sample;
  logic [W_EP-1:0]                      frame_word;
  logic                                 data_write;
  logic                                 unused_sample_bits;
`ifdef PIPE_SCHED_HEADER_EN
  logic [7:0]                           seq;
`endif

  assign request = pending & chan_enable_in;

  rr_arbiter #(
    .N     (N_ADC),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .request      (request),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  always_comb begin
    sel_sample = '0;
    for (int a = 0; a < N_ADC; a++) begin
      if (grant_onehot[a]) sel_sample = sel_sample | held[a];
    end
  end

  // Only the top W_EP bits of a sample travel down the pipe.
  assign unused_sample_bits = ^sel_sample;

  always_ff @(posedge clk50_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Write strobe is also gated by reset so a frame cut by reset never leaks another word.
  always_comb begin
    state_next     = state;
    fifo_wr_en_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) state_next = GRANT_STATE;
      end
      ST_HEADER: begin
        fifo_wr_en_out = rst_n_in & ~fifo_full_in;
        if (!fifo_full_in) state_next = ST_DATA;
      end
      ST_DATA: begin
        fifo_wr_en_out = rst_n_in & ~fifo_full_in;
        if (!fifo_full_in) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data_write = (state == ST_DATA) && !fifo_full_in;

  // A strobe landing on the data-write cycle of its own channel refills the slot instead of dropping.
  always_ff @(posedge clk50_in) begin
    if (!rst_n_in) begin
      pending    <= '0;
      held       <= '0;
      drop_cnt   <= '0;
      cur_chan   <= '0;
      last_grant <= LAST_IDX;
      frame_word <= '0;
`ifdef PIPE_SCHED_HEADER_EN
      seq        <= '0;
`endif
    end else begin
      for (int a = 0; a < N_ADC; a++) begin
        if (!chan_enable_in[a]) begin
          pending[a] <= 1'b0;
        end else if (osf_data_valid_in[a]) begin
          if (!pending[a] || (data_write && cur_chan == IDX_W'(a))) begin
            held[a]    <= osf_data_packed_in[a*W_ADC_DATA +: W_ADC_DATA];
            pending[a] <= 1'b1;
          end else if (drop_cnt[a] != '1) begin
            drop_cnt[a] <= drop_cnt[a] + DROP_CNT_W'(1);
          end
        end else if (data_write && cur_chan == IDX_W'(a)) begin
          pending[a] <= 1'b0;
        end
      end

      if (state == ST_IDLE && grant_valid) begin
        cur_chan   <= grant_idx;
        frame_word <= sel_sample[W_ADC_DATA-1 -: W_EP];
      end

      if (data_write) begin
        last_grant <= cur_chan;
`ifdef PIPE_SCHED_HEADER_EN
        seq        <= seq + 8'd1;
`endif
      end
    end
  end

`ifdef PIPE_SCHED_HEADER_EN
  assign fifo_data_out = (state == ST_HEADER) ? W_EP'({HEADER_TAG, 4'(cur_chan), seq}) : frame_word;
`else
  assign fifo_data_out = frame_word;
`endif

  assign drop_count_out = drop_cnt;
  assign busy_out       = (state != ST_IDLE);

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have parameter N_ADC, default 8: number of oversample-filter channels sharing the pipe.
REQ-002 SHALL have parameter W_ADC_DATA, default 18: width of each channel sample.
REQ-003 SHALL have parameter W_EP, default 16: pipe word width.
REQ-004 SHALL have port clk50_in, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port osf_data_valid_in, input, N_ADC: per-channel one-cycle sample strobe.
REQ-007 SHALL have port osf_data_packed_in, input, N_ADC*W_ADC_DATA: channel a at bits [a*W_ADC_DATA +: W_ADC_DATA].
REQ-008 SHALL have port chan_enable_in, input, N_ADC: host mask of channels admitted to the pipe.
REQ-009 SHALL have port fifo_full_in, input, 1: downstream pipe FIFO cannot accept a word.
REQ-010 SHALL have port fifo_wr_en_out, output, 1: write strobe, one word per asserted cycle.
REQ-011 SHALL have port fifo_data_out, output, W_EP: word to write.
REQ-012 SHALL have port drop_count_out, output, N_ADC*8: per-channel saturating drop counters, channel a at [a*8 +: 8].
REQ-013 SHALL have port busy_out, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL keep one holding register and one pending flag per channel; on a valid strobe for an enabled channel with pending=0, it captures the sample and sets pending on that edge.
REQ-015 SHALL drop a sample arriving while its channel is pending and not being cleared that cycle, keep the held sample, and increment that channel's drop counter, saturating at 255.
REQ-016 SHALL treat a sample arriving in the same cycle its channel's data word is written as a fresh capture: pending stays 1, no drop.
REQ-017 SHALL clear pending and ignore strobes for any channel while chan_enable_in is low; a frame already in progress for that channel completes.
REQ-018 SHALL implement states IDLE, HEADER, DATA; from IDLE, when any channel is pending and enabled, it grants the first such channel in round-robin order starting at last_grant+1 (mod N_ADC) and moves to HEADER.
REQ-019 SHALL, in HEADER, drive fifo_data_out = {4'hA, chan[3:0], seq[7:0]}, assert fifo_wr_en_out only when fifo_full_in=0, and go to DATA only on a write.
REQ-020 SHALL, in DATA, drive fifo_data_out = held_sample[W_ADC_DATA-1 -: W_EP], assert fifo_wr_en_out only when fifo_full_in=0, and on that write clear the channel's pending, set last_grant, increment seq (8-bit, wraps 255->0), and return to IDLE.
REQ-021 SHALL freeze the current state and word while fifo_full_in=1; no word is lost or duplicated.
REQ-022 SHALL produce the header word two cycles after the strobe edge when idle and not full: capture at edge t, grant at edge t+1, header strobe in cycle t+1..t+2, data in the following cycle.
REQ-023 SHALL drive fifo_wr_en_out combinationally from state and fifo_full_in, and all other outputs from registers.

Reset
REQ-024 SHALL, when rst_n_in=0 at a clock edge, reset state to IDLE, all pending flags, holding registers, drop counters and seq to 0, and last_grant to N_ADC-1 so that channel 0 is served first.
REQ-025 SHALL, on reset mid-frame, discard the partial frame; no further word of that frame is written.

Configuration
REQ-026 SHALL, with macro PIPE_SCHED_HEADER_EN defined, emit two-word frames (HEADER then DATA).
REQ-027 SHALL, with PIPE_SCHED_HEADER_EN undefined, skip HEADER (IDLE->DATA), emit data words only, and not implement seq.

Structure
REQ-028 SHALL take the header tag 4'hA, the state encoding and the drop-counter width 8 from a shared package or include used by the host software map.
REQ-029 SHALL place the round-robin arbiter (request, last_grant -> one-hot grant and index) in sub-module rr_arbiter; the rest of the logic is flat.

Verification
REQ-030 SHALL verify: channel 3 strobe with data 18'h2ABCD, not full -> words 16'hA300, then 16'hAAF3.
REQ-031 SHALL verify: channels 0, 2 and 5 strobe together -> frames in order 0, 2, 5; seq 0, 1, 2.
REQ-032 SHALL verify: fifo_full_in held high for 10 cycles in HEADER -> no writes, then the same header and data are written once.
REQ-033 SHALL verify: channel 1 strobes 300 times while full -> drop_count for channel 1 saturates at 255 and the first sample is delivered.
REQ-034 SHALL verify: chan_enable_in[4]=0 with channel 4 strobing -> no frames from channel 4 and its drop_count stays 0.
REQ-035 SHALL verify: rst_n_in low for one cycle while in DATA -> no data word written, all counters are 0, and the next grant goes to channel 0.
